// File: rtl/mul_share_pkg.sv
// mul_share_pkg: slot states, default widths and output wrap/saturate helpers
package mul_share_pkg;
    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} slot_t;
    localparam int DIN0_W = 8;
    localparam int DIN1_W = 4;
    localparam int DOUT_W = 8;
    function automatic logic signed [31:0] sat_trunc(input logic signed [31:0] product, input int dw, input logic sat_en);
        logic signed [31:0] hi, lo;
        hi = (32'sd1 <<< (dw - 1)) - 32'sd1;
        lo = -hi - 32'sd1;
        return !sat_en ? product : product > hi ? hi : product < lo ? lo : product;
    endfunction
    function automatic logic sat_hit(input logic signed [31:0] product, input int dw);
        logic signed [31:0] hi, lo;
        hi = (32'sd1 <<< (dw - 1)) - 32'sd1;
        lo = -hi - 32'sd1;
        return product > hi || product < lo;
    endfunction
endpackage

// File: rtl/mul_share_mul.sv
// mul_share_mul: combinational signed multiplier, full-width product
module mul_share_mul #(
    parameter int A_W = 8,
    parameter int B_W = 4
) (
    input  logic signed [A_W-1:0]     a,
    input  logic signed [B_W-1:0]     b,
    output logic signed [A_W+B_W-1:0] p
);
    assign p = a * b;
endmodule

// File: rtl/mul_share_rr_pick.sv
// mul_share_rr_pick: first valid requester at or above ptr, with wrap
module mul_share_rr_pick #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  valid,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx
);
    always_comb begin
        grant = '0;
        idx   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (valid[(int'(ptr) + k) % N]) begin
                idx   = IW'((int'(ptr) + k) % N);
                grant = N'(1) << idx;
            end
        end
    end
endmodule

// File: rtl/mul_share_arbiter.sv
// mul_share_arbiter: round-robin share of one multiplier; MUL_SHARE_SAT_EN clamps results and adds rsp_sat
module mul_share_arbiter
    import mul_share_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DIN0_WIDTH = DIN0_W,
    parameter int DIN1_WIDTH = DIN1_W,
    parameter int DOUT_WIDTH = DOUT_W,
    parameter int BURST_LEN  = 2,
    parameter int ID_W       = $clog2(NUM_REQ)
) (
    input  logic                          ap_clk,
    input  logic                          ap_rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*DIN0_WIDTH-1:0] req_din0,
    input  logic [NUM_REQ*DIN1_WIDTH-1:0] req_din1,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [DOUT_WIDTH-1:0]         rsp_dout,
`ifdef MUL_SHARE_SAT_EN
    output logic                          rsp_sat,
`endif
    output logic [ID_W-1:0]               rsp_id
);
    localparam int PW = DIN0_WIDTH + DIN1_WIDTH;
    localparam int CW = $clog2(BURST_LEN + 1);
`ifdef MUL_SHARE_SAT_EN
    localparam logic SAT_EN = 1'b1;
`else
    localparam logic SAT_EN = 1'b0;
`endif
    slot_t                         state;
    logic [ID_W-1:0]               rr_ptr, gidx, nxt;
    logic [CW-1:0]                 burst_cnt, cnt_n;
    logic [NUM_REQ-1:0]            grant;
    logic                          can_issue, accept, rotate;
    logic signed [DIN0_WIDTH-1:0]  op_a;
    logic signed [DIN1_WIDTH-1:0]  op_b;
    logic signed [PW-1:0]          prod;
    logic signed [31:0]            pext;
    logic [DOUT_WIDTH-1:0]         dout_next;
    mul_share_rr_pick #(.N(NUM_REQ), .IW(ID_W)) u_pick (
        .valid(req_valid),
        .ptr  (rr_ptr),
        .grant(grant),
        .idx  (gidx)
    );
    mul_share_mul #(.A_W(DIN0_WIDTH), .B_W(DIN1_WIDTH)) u_mul (
        .a(op_a),
        .b(op_b),
        .p(prod)
    );
    assign rsp_valid = state == FULL;
    assign can_issue = !rsp_valid || rsp_ready;
    assign req_ready = (can_issue && !ap_rst) ? grant : '0;
    assign accept    = |(req_valid & req_ready);
    assign op_a      = req_din0[gidx*DIN0_WIDTH +: DIN0_WIDTH];
    assign op_b      = req_din1[gidx*DIN1_WIDTH +: DIN1_WIDTH];
    assign pext      = {{(32 - PW){prod[PW-1]}}, prod};
    assign dout_next = DOUT_WIDTH'(sat_trunc(pext, DOUT_WIDTH, SAT_EN));
    // a grant away from rr_ptr restarts the burst at that requester
    assign cnt_n     = (gidx == rr_ptr) ? burst_cnt + CW'(1) : CW'(1);
    assign rotate    = cnt_n == CW'(BURST_LEN);
    assign nxt       = (gidx == ID_W'(NUM_REQ - 1)) ? '0 : gidx + ID_W'(1);
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state     <= EMPTY;
            rsp_dout  <= '0;
            rsp_id    <= '0;
            rr_ptr    <= '0;
            burst_cnt <= '0;
        end else if (accept) begin
            state     <= FULL;
            rsp_dout  <= dout_next;
            rsp_id    <= gidx;
            rr_ptr    <= rotate ? nxt : gidx;
            burst_cnt <= rotate ? '0 : cnt_n;
        end else if (rsp_ready) begin
            state     <= EMPTY;
        end
    end
`ifdef MUL_SHARE_SAT_EN
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst)
            rsp_sat <= 1'b0;
        else if (accept)
            rsp_sat <= sat_hit(pext, DOUT_WIDTH);
    end
`endif
endmodule

// File: tb/tb_mul_share_arbiter.sv
// tb_mul_share_arbiter: directed vectors with a queue scoreboard checked on response handshakes
module tb_mul_share_arbiter;
    typedef struct {int id; int dout; int sat;} exp_t;
    logic        ap_clk = 1'b0;
    logic        ap_rst = 1'b0;
    logic [3:0]  req_valid = '0;
    logic [3:0]  req_ready;
    logic [31:0] req_din0 = '0;
    logic [15:0] req_din1 = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [7:0]  rsp_dout;
    logic [1:0]  rsp_id;
`ifdef MUL_SHARE_SAT_EN
    logic        rsp_sat;
`endif
    exp_t        q[$];
    int          vectors = 0;
    int          miscompares = 0;

    mul_share_arbiter dut (
        .ap_clk   (ap_clk),
        .ap_rst   (ap_rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_din0 (req_din0),
        .req_din1 (req_din1),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_dout (rsp_dout),
`ifdef MUL_SHARE_SAT_EN
        .rsp_sat  (rsp_sat),
`endif
        .rsp_id   (rsp_id)
    );

    always #5 ap_clk = ~ap_clk;

    task automatic chk(input string nm, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic push(input int id, input int dout, input int sat);
        exp_t e;
        e.id = id;
        e.dout = dout;
        e.sat = sat;
        q.push_back(e);
    endtask

    task automatic set_req(input int i, input int a, input int b);
        req_din0[i*8 +: 8] = 8'(a);
        req_din1[i*4 +: 4] = 4'(b);
        req_valid[i] = 1'b1;
    endtask

    task automatic do_reset();
        ap_rst = 1'b1;
        #1;
        chk("rst rsp_valid", int'(rsp_valid), 0);
        chk("rst rsp_dout", int'(rsp_dout), 0);
        chk("rst rsp_id", int'(rsp_id), 0);
        chk("rst req_ready", int'(req_ready), 0);
        @(posedge ap_clk);
        #1;
        ap_rst = 1'b0;
    endtask

    task automatic pump(input int n);
        int got = 0;
        int t = 0;
        while (got < n && t < 100) begin
            @(negedge ap_clk);
            if (|(req_valid & req_ready)) got++;
            t++;
            @(posedge ap_clk);
            #1;
        end
        if (got < n) chk("accept timeout", got, n);
    endtask

    always @(negedge ap_clk) begin
        if (!ap_rst && rsp_valid && rsp_ready) begin
            if (q.size() == 0) begin
                chk("unexpected response", int'(rsp_id), -1);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("rsp_id", int'(rsp_id), e.id);
                chk("rsp_dout", int'($signed(rsp_dout)), e.dout);
`ifdef MUL_SHARE_SAT_EN
                chk("rsp_sat", int'(rsp_sat), e.sat);
`endif
            end
        end
    end

    initial begin
        int ids[10] = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};
        int vals[4] = '{3, -8, -50, 49};
        #2;
        do_reset();
        // single requester, 1-cycle latency
        push(0, -15, 0);
        set_req(0, 5, -3);
        pump(1);
        req_valid = '0;
        chk("latency rsp_valid", int'(rsp_valid), 1);
        repeat (2) @(posedge ap_clk);
        #1;
        // all requesters, burst rotation
        do_reset();
        set_req(0, 3, 1);
        set_req(1, -4, 2);
        set_req(2, 10, -5);
        set_req(3, -7, -7);
        foreach (ids[i]) push(ids[i], vals[ids[i]], 0);
        pump(10);
        req_valid = '0;
        repeat (2) @(posedge ap_clk);
        #1;
        // overflow wrap / saturation
        do_reset();
`ifdef MUL_SHARE_SAT_EN
        push(0, 127, 1);
        push(0, 127, 1);
`else
        push(0, 121, 0);
        push(0, 0, 0);
`endif
        set_req(0, 127, 7);
        pump(1);
        set_req(0, -128, -8);
        pump(1);
        req_valid = '0;
        repeat (2) @(posedge ap_clk);
        #1;
        // stall with full slot, then same-cycle accept on release
        do_reset();
        rsp_ready = 1'b0;
        push(0, 18, 0);
        set_req(0, 6, 3);
        pump(1);
        req_valid = '0;
        push(1, -4, 0);
        set_req(1, 2, -2);
        repeat (3) begin
            @(negedge ap_clk);
            chk("stall req_ready", int'(req_ready), 0);
            chk("stall rsp_dout", int'(rsp_dout), 18);
            chk("stall rsp_id", int'(rsp_id), 0);
            chk("stall rsp_valid", int'(rsp_valid), 1);
            @(posedge ap_clk);
            #1;
        end
        rsp_ready = 1'b1;
        @(negedge ap_clk);
        chk("release req_ready", int'(req_ready), 2);
        @(posedge ap_clk);
        #1;
        req_valid = '0;
        repeat (2) @(posedge ap_clk);
        #1;
        // reset while full with pending requesters
        do_reset();
        rsp_ready = 1'b0;
        set_req(3, 1, 1);
        pump(1);
        req_valid = '0;
        set_req(1, 3, 3);
        set_req(2, -2, 4);
        @(posedge ap_clk);
        #2;
        do_reset();
        rsp_ready = 1'b1;
        push(1, 9, 0);
        push(1, 9, 0);
        push(2, -8, 0);
        @(negedge ap_clk);
        chk("post-reset grant", int'(req_ready), 2);
        @(posedge ap_clk);
        #1;
        pump(2);
        req_valid = '0;
        repeat (2) @(posedge ap_clk);
        #1;
        // late joiner mid-burst, then lone requester without bubbles
        do_reset();
        set_req(2, 5, 5);
        push(2, 25, 0);
        pump(1);
        set_req(1, -3, 3);
        push(2, 25, 0);
        push(1, -9, 0);
        push(1, -9, 0);
        push(2, 25, 0);
        pump(4);
        req_valid[1] = 1'b0;
        repeat (3) begin
            push(2, 25, 0);
            @(negedge ap_clk);
            chk("lone req_ready", int'(req_ready), 4);
            @(posedge ap_clk);
            #1;
        end
        req_valid = '0;
        repeat (5) @(posedge ap_clk);
        #1;
        chk("scoreboard drained", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
